core_sequencer: RTL and testbench

Multi-cycle control FSM for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback. It handshakes with instruction and data memory, and drives the write enables and mux selects for the PC, the instruction register, the register file and the writeback path. It sits beside the decoder and consumes its instruction-class flags.

---
 rtl/core_ctrl_pkg.sv | 26 ++
 rtl/mem_wait_timer.sv | 38 +++
 rtl/core_sequencer.sv | 131 +++++++++++++
 tb/tb_core_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg
// Shared definitions for the multi-cycle RV32I control path: the sequencer
// state encoding (also exported on the debug state port), the writeback
// source select codes and the PC source select codes.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  // Writeback source select
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // PC source select
  localparam logic PC_PLUS4  = 1'b0;
  localparam logic PC_TARGET = 1'b1;

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer
// Counts the cycles a memory request has been waiting without an ack and
// flags the cycle in which the wait budget is exhausted.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   clr       - restart the count (asserted on every state change)
//   busy      - a request is outstanding this cycle
//   ack       - the memory answered this cycle
//   expired   - last allowed cycle reached and still no ack
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic busy,
  input  logic ack,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (busy && !ack)
      count <= count + 1'b1;
  end

  // An ack in the final cycle still wins over the timeout.
  assign expired = busy && !ack && (count == LAST);

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer
// Multi-cycle control FSM of the RV32I core: FETCH, DECODE, EXECUTE,
// optional MEM, WRITEBACK. Drives the memory handshakes and the write
// enables / mux selects of the datapath, halts on ECALL or memory timeout.
// Ports:
//   clk, rst                    - clock, asynchronous active-low reset
//   run                         - start/continue (sampled in IDLE, WRITEBACK)
//   imem_req/imem_ack, ir_we    - instruction fetch handshake, IR latch
//   is_* / writes_rd            - decoder class flags
//   branch_taken                - ALU compare result
//   dmem_req/dmem_we/dmem_ack   - data memory handshake
//   pc_we, pc_sel, rf_we, wb_sel- datapath controls
//   state, halted, fault        - status
//   instret                     - retired instruction counter
module core_sequencer
  import core_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_we,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_branch,
  input  logic        is_jump,
  input  logic        is_ecall,
  input  logic        writes_rd,
  input  logic        branch_taken,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instret
);

  state_t cur_state, next_state;
  logic   busy, ack, expired;

  assign busy = (cur_state == S_FETCH) || (cur_state == S_MEM);
  assign ack  = (cur_state == S_FETCH) ? imem_ack : dmem_ack;

  mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (next_state != cur_state),
    .busy    (busy),
    .ack     (ack),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cur_state <= S_IDLE;
    else
      cur_state <= next_state;
  end

  // fault is sticky until reset; instret counts every WRITEBACK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault   <= 1'b0;
      instret <= '0;
    end else begin
      if (expired)
        fault <= 1'b1;
      if (cur_state == S_WRITEBACK)
        instret <= instret + 32'd1;
    end
  end

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      S_IDLE:      if (run) next_state = S_FETCH;
      S_FETCH:     if (imem_ack) next_state = S_DECODE;
                   else if (expired) next_state = S_HALT;
      S_DECODE:    next_state = is_ecall ? S_HALT : S_EXECUTE;
      S_EXECUTE:   next_state = (is_load || is_store) ? S_MEM : S_WRITEBACK;
      S_MEM:       if (dmem_ack) next_state = S_WRITEBACK;
                   else if (expired) next_state = S_HALT;
      S_WRITEBACK: next_state = run ? S_FETCH : S_IDLE;
      S_HALT:      next_state = S_HALT;
      default:     next_state = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_PLUS4;
    rf_we    = 1'b0;
    wb_sel   = WB_ALU;
    case (cur_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
      end
      S_WRITEBACK: begin
        pc_we  = 1'b1;
        pc_sel = (is_jump || (is_branch && branch_taken)) ? PC_TARGET : PC_PLUS4;
        rf_we  = writes_rd && !is_store && !is_branch;
        if (is_jump)
          wb_sel = WB_PC4;
        else if (is_load)
          wb_sel = WB_MEM;
      end
      default: ;
    endcase
  end

  assign state  = cur_state;
  assign halted = (cur_state == S_HALT);

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer
// Drives instructions through core_sequencer with directed and random memory
// latencies and compares the state trace, handshake counts and writeback
// controls against an instruction-level reference model.
module tb_core_sequencer;

  localparam int T = 4;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BRANCH = 3, K_JUMP = 4, K_ECALL = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        imem_req, imem_ack = 1'b0, ir_we;
  logic        is_load = 1'b0, is_store = 1'b0, is_branch = 1'b0;
  logic        is_jump = 1'b0, is_ecall = 1'b0, writes_rd = 1'b0;
  logic        branch_taken = 1'b0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic        pc_we, pc_sel, rf_we;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
  logic        halted, fault;
  logic [31:0] instret;

  int          total = 0;
  int          bad = 0;
  logic [31:0] model_instret = '0;

  core_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
    .is_jump(is_jump), .is_ecall(is_ecall), .writes_rd(writes_rd),
    .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
    .state(state), .halted(halted), .fault(fault), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Async reset: strobes and state must drop without a clock edge.
  task automatic applyReset();
    rst = 1'b0;
    run = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1;
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
    checkOutput("rst_dmem_req", 32'(dmem_req), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    checkOutput("rst_instret", instret, 32'd0);
    checkOutput("rst_wb", {27'd0, pc_we, pc_sel, rf_we, wb_sel}, 32'd0);
    model_instret = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One instruction: kind, fetch/mem ack delays (>=T means never), run after.
  task automatic applyStimulus(input int kind, input int fd, input int md,
                               input logic taken, input logic wrd, input logic run_next);
    int   exp_trace[$];
    int   got_trace[$];
    int   fc = 0, mc = 0, n_imem = 0, n_ir = 0, n_dmem = 0, n_dwe_bad = 0, mism = 0;
    int   exp_imem, exp_ir, exp_dmem;
    logic exp_halt = 1'b0, exp_fault = 1'b0, mem_op, done = 1'b0, saw_wb = 1'b0;
    logic got_pc_sel = 1'bx, got_rf_we = 1'bx;
    logic [1:0] got_wb_sel = 2'bxx, exp_wb_sel;

    is_load      = (kind == K_LOAD);
    is_store     = (kind == K_STORE);
    is_branch    = (kind == K_BRANCH);
    is_jump      = (kind == K_JUMP);
    is_ecall     = (kind == K_ECALL);
    writes_rd    = wrd;
    branch_taken = taken;
    mem_op       = is_load || is_store;

    // Reference: expected state trace built from the instruction's phases.
    exp_imem = (fd >= T) ? T : fd + 1;
    exp_ir   = (fd >= T) ? 0 : 1;
    exp_dmem = 0;
    for (int i = 0; i < exp_imem; i++) exp_trace.push_back(1);
    if (fd >= T) begin
      exp_halt = 1'b1; exp_fault = 1'b1;
    end else begin
      exp_trace.push_back(2);
      if (kind == K_ECALL) exp_halt = 1'b1;
      else begin
        exp_trace.push_back(3);
        if (mem_op) begin
          exp_dmem = (md >= T) ? T : md + 1;
          for (int i = 0; i < exp_dmem; i++) exp_trace.push_back(4);
          if (md >= T) begin exp_halt = 1'b1; exp_fault = 1'b1; end
        end
        if (!exp_halt) exp_trace.push_back(5);
      end
    end
    exp_wb_sel = (kind == K_JUMP) ? 2'b10 : (kind == K_LOAD) ? 2'b01 : 2'b00;

    if (state == 3'd0) begin
      run = 1'b1;
      @(posedge clk); @(negedge clk);
    end

    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      imem_ack = imem_req ? (fc == fd) : 1'($urandom_range(0, 1));
      dmem_ack = dmem_req ? (mc == md) : 1'($urandom_range(0, 1));
      #1;
      if (state == 3'd6) done = 1'b1;
      else begin
        got_trace.push_back(int'(state));
        if (imem_req) begin n_imem++; fc++; end
        if (ir_we) n_ir++;
        if (dmem_req) begin
          n_dmem++; mc++;
          if (dmem_we !== is_store) n_dwe_bad++;
        end
        if (pc_we) begin
          saw_wb = 1'b1;
          got_pc_sel = pc_sel; got_rf_we = rf_we; got_wb_sel = wb_sel;
        end
        if (cyc == 0) run = run_next;
        @(posedge clk); @(negedge clk);
        if (saw_wb) done = 1'b1;
      end
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;

    checkOutput("cycle_budget", 32'(done), 32'd1);
    checkOutput("latency", 32'(got_trace.size()), 32'(exp_trace.size()));
    for (int i = 0; i < got_trace.size() && i < exp_trace.size(); i++)
      if (got_trace[i] != exp_trace[i]) mism++;
    checkOutput("state_trace", 32'(mism), 32'd0);
    checkOutput("imem_req_cycles", 32'(n_imem), 32'(exp_imem));
    checkOutput("ir_we_cycles", 32'(n_ir), 32'(exp_ir));
    checkOutput("dmem_req_cycles", 32'(n_dmem), 32'(exp_dmem));
    checkOutput("dmem_we", 32'(n_dwe_bad), 32'd0);

    if (exp_halt) begin
      checkOutput("halt_state", 32'(state), 32'd6);
      checkOutput("halted", 32'(halted), 32'd1);
      checkOutput("fault", 32'(fault), 32'(exp_fault));
      checkOutput("halt_instret", instret, model_instret);
      applyReset();
    end else begin
      model_instret = model_instret + 32'd1;
      checkOutput("pc_sel", 32'(got_pc_sel), 32'(is_jump || (is_branch && taken)));
      checkOutput("rf_we", 32'(got_rf_we), 32'(wrd && !is_store && !is_branch));
      checkOutput("wb_sel", 32'(got_wb_sel), 32'(exp_wb_sel));
      checkOutput("instret", instret, model_instret);
      checkOutput("next_state", 32'(state), run_next ? 32'd1 : 32'd0);
      checkOutput("no_fault", 32'(fault), 32'd0);
    end
  endtask

  initial begin
    int kind, fd, md;
    $display("[TB] start");
    applyReset();

    // ADDI, zero wait
    applyStimulus(K_ALU, 0, 0, 1'b0, 1'b1, 1'b1);
    // LW, ack in the final allowed MEM cycle
    applyStimulus(K_LOAD, 0, 3, 1'b0, 1'b1, 1'b1);
    // SW, taken BEQ, JAL then stop
    applyStimulus(K_STORE, 0, 0, 1'b0, 1'b1, 1'b1);
    applyStimulus(K_BRANCH, 0, 0, 1'b1, 1'b1, 1'b1);
    applyStimulus(K_JUMP, 0, 0, 1'b0, 1'b1, 1'b0);
    // Fetch timeout, then fetch ack in the final allowed cycle
    applyStimulus(K_ALU, 99, 0, 1'b0, 1'b1, 1'b1);
    applyStimulus(K_ALU, 3, 0, 1'b0, 1'b1, 1'b0);
    // ECALL halts without fault
    applyStimulus(K_ECALL, 1, 0, 1'b0, 1'b0, 1'b1);

    // Reset while a load is waiting on dmem
    applyStimulus(K_ALU, 0, 0, 1'b0, 1'b1, 1'b0);
    is_load = 1'b1; is_store = 1'b0; is_branch = 1'b0; is_jump = 1'b0;
    is_ecall = 1'b0; writes_rd = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 10 && !dmem_req; i++) begin
      imem_ack = imem_req;
      dmem_ack = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    imem_ack = 1'b0;
    checkOutput("dmem_req_before_rst", 32'(dmem_req), 32'd1);
    applyReset();

    // instret wrap
    force dut.instret = 32'hFFFF_FFFF;
    #1;
    release dut.instret;
    #1;
    checkOutput("instret_preload", instret, 32'hFFFF_FFFF);
    model_instret = 32'hFFFF_FFFF;
    applyStimulus(K_ALU, 0, 0, 1'b0, 1'b1, 1'b0);

    // Random instruction mix with random latencies
    for (int n = 0; n < 40; n++) begin
      kind = ($urandom_range(0, 19) == 0) ? K_ECALL : int'($urandom_range(0, 4));
      fd   = ($urandom_range(0, 9) == 0) ? T : int'($urandom_range(0, 3));
      md   = ($urandom_range(0, 9) == 0) ? T : int'($urandom_range(0, 3));
      applyStimulus(kind, fd, md, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
